// File: rtl/fpga_rst_status.sv
// fpga_rst_status: board reset / PLL lock sequencer with staggered domain
// releases, a software reset path and status LEDs.
//
// state   | meaning
// HOLD    | all domains in reset, debouncing board reset and PLL lock
// RELEASE | domains leave reset one by one, StretchCycles apart
// RUN     | all domains out of reset, ready_o high
// SWRST   | software-requested reset, held StretchCycles, no debounce
//
// Ports:
//   clk_i         single clock, rising edge
//   rst_i         asynchronous active-high reset
//   board_rst_ni  asynchronous board reset, active-low (synchronized here)
//   pll_locked_i  asynchronous PLL lock (synchronized here)
//   sw_rst_req_i  one-cycle software reset request, honoured only in RUN
//   exit_i        SoC exit word: bit0 valid, bits[63:1] exit code
//   rst_no        per-domain active-low resets, registered
//   ready_o       high while in RUN
//   state_o       current state (HOLD=0, RELEASE=1, RUN=2, SWRST=3)
//   led_o         [0] heartbeat, [1] exit seen, [2] nonzero exit code,
//                 [3] lock lost, upper bits tied low
module fpga_rst_status #(
  parameter int NrDomains      = 3,
  parameter int DebounceCycles = 1024,
  parameter int StretchCycles  = 16,
  parameter int HeartbeatDiv   = 25_000_000,
  parameter int NrLeds         = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 board_rst_ni,
  input  logic                 pll_locked_i,
  input  logic                 sw_rst_req_i,
  input  logic [63:0]          exit_i,
  output logic [NrDomains-1:0] rst_no,
  output logic                 ready_o,
  output logic [1:0]           state_o,
  output logic [NrLeds-1:0]    led_o
);

  // One counter serves debounce, release stagger and software-reset hold.
  localparam int RelMax  = (NrDomains - 1) * StretchCycles;
  localparam int CntMaxA = (DebounceCycles - 1 > RelMax) ? DebounceCycles - 1 : RelMax;
  localparam int CntMax  = (CntMaxA > StretchCycles - 1) ? CntMaxA : StretchCycles - 1;
  localparam int CntW    = $clog2(CntMax + 1);
  localparam int HbW     = $clog2(HeartbeatDiv);

  localparam logic [CntW-1:0] DebLast = CntW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] RelLast = CntW'(RelMax);
  localparam logic [CntW-1:0] SwLast  = CntW'(StretchCycles - 1);
  localparam logic [HbW-1:0]  HbLast  = HbW'(HeartbeatDiv - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    SWRST   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [NrDomains-1:0]  rst_q, rst_d;
  logic [1:0]            board_s, lock_s;
  logic [HbW-1:0]        hb_cnt_q, hb_cnt_d;
  logic                  hb_q, hb_d;
  logic                  exit_seen_q, exit_seen_d;
  logic                  exit_code_q, exit_code_d;
  logic                  lock_lost_q, lock_lost_d;
  logic                  good;
  logic                  hold_entry;

  assign good = board_s[1] & lock_s[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    unique case (state_q)
      HOLD: begin
        rst_d = '0;
        if (!good) begin
          cnt_d = '0;
        end else if (cnt_q == DebLast) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!good) begin
          state_d = HOLD;
          cnt_d   = '0;
          rst_d   = '0;
        end else begin
          // counter only climbs, so domains release strictly in index order
          for (int k = 0; k < NrDomains; k++) begin
            if (cnt_q == CntW'(k * StretchCycles)) rst_d[k] = 1'b1;
          end
          if (cnt_q == RelLast) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (!good) begin
          state_d = HOLD;
          cnt_d   = '0;
          rst_d   = '0;
        end else if (sw_rst_req_i) begin
          state_d = SWRST;
          cnt_d   = '0;
          rst_d   = '0;
        end
      end
      SWRST: begin
        rst_d = '0;
        if (!good) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == SwLast) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
        rst_d   = '0;
      end
    endcase
  end

  assign hold_entry = (state_q != HOLD) && (state_d == HOLD);

  always_comb begin
    hb_cnt_d    = hb_cnt_q;
    hb_d        = hb_q;
    exit_seen_d = exit_seen_q;
    exit_code_d = exit_code_q;
    // heartbeat follows the next state so it is low in the same cycle RUN is left
    if (state_d != RUN) begin
      hb_cnt_d = '0;
      hb_d     = 1'b0;
    end else if (state_q == RUN) begin
      if (hb_cnt_q == HbLast) begin
        hb_cnt_d = '0;
        hb_d     = ~hb_q;
      end else begin
        hb_cnt_d = hb_cnt_q + 1'b1;
      end
    end
    if (hold_entry) begin
      exit_seen_d = 1'b0;
      exit_code_d = 1'b0;
    end else if (state_q == RUN && exit_i[0]) begin
      exit_seen_d = 1'b1;
      if (|exit_i[63:1]) exit_code_d = 1'b1;
    end
    // synchronized lock is about to fall (stage 1 already low)
    lock_lost_d = lock_lost_q | ((state_q != HOLD) && lock_s[1] && !lock_s[0]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      rst_q       <= '0;
      board_s     <= '0;
      lock_s      <= '0;
      hb_cnt_q    <= '0;
      hb_q        <= 1'b0;
      exit_seen_q <= 1'b0;
      exit_code_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_q       <= rst_d;
      board_s     <= {board_s[0], board_rst_ni};
      lock_s      <= {lock_s[0], pll_locked_i};
      hb_cnt_q    <= hb_cnt_d;
      hb_q        <= hb_d;
      exit_seen_q <= exit_seen_d;
      exit_code_q <= exit_code_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign rst_no  = rst_q;
  assign ready_o = (state_q == RUN);
  assign state_o = state_q;

  always_comb begin
    led_o      = '0;
    led_o[3:0] = {lock_lost_q, exit_code_q, exit_seen_q, hb_q};
  end

endmodule
